// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory controller and its bus timer.
package data_mem_pkg;

  localparam int DATA_W = 16;
  localparam int TIMEOUT_CYCLES_DEF = 15;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } req_t;

  // The timer is never narrower than 4 bits so small timeouts still fit comfortably.
  function automatic int timerWidth(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/data_mem_timer.sv
// Bus watchdog: counts enabled cycles from a clear and flags the last allowed cycle.
module data_mem_timer
  import data_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = timerWidth(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Saturates on the final counted cycle instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: latches a processor load/store and runs it on a req/ack bus with timeout.
// Define DATA_MEM_WRITE_BUFFER_EN to post writes (early DataDone, bus write drained afterwards).
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int                  WORD_SIZE      = DATA_W,
  parameter int                  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [WORD_SIZE-1:0] ERR_DATA      = ERR_DATA_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WORD_SIZE-1:0] dataAddr_i,
  input  logic [WORD_SIZE-1:0] dataOut_i,
  input  logic                 readData_i,
  input  logic                 writeData_i,
  output logic [WORD_SIZE-1:0] dataIn_o,
  output logic                 dataDone_o,
  output logic                 memReq_o,
  output logic                 memWe_o,
  output logic [WORD_SIZE-1:0] memAddr_o,
  output logic [WORD_SIZE-1:0] memWData_o,
  input  logic [WORD_SIZE-1:0] memRData_i,
  input  logic                 memAck_i,
  output logic                 busErr_o,
  output logic                 busy_o
);

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  logic [WORD_SIZE-1:0] resp_q, resp_d;
  logic                 busErr_q, busErr_d;
  logic                 memReq;
  logic                 dataDone;
  logic                 expired;

  data_mem_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (!memReq),
    .enable_i (memReq),
    .expired_o(expired)
  );

  // An ack in the final counted cycle is checked before the timeout so it wins.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    resp_d   = resp_q;
    busErr_d = busErr_q;
    memReq   = 1'b0;
    dataDone = 1'b0;
    unique case (state_q)
      IDLE: begin
        dataDone = !(readData_i || writeData_i);
        if (readData_i || writeData_i) begin
          req_d.addr  = dataAddr_i;
          req_d.wdata = dataOut_i;
          req_d.we    = writeData_i;
`ifdef DATA_MEM_WRITE_BUFFER_EN
          if (writeData_i) begin
            resp_d  = '0;
            state_d = RESP;
          end else begin
            state_d = BUS;
          end
`else
          state_d = BUS;
`endif
        end
      end
      BUS: begin
        memReq = 1'b1;
        if (memAck_i) begin
          resp_d  = req_q.we ? '0 : memRData_i;
          state_d = RESP;
        end else if (expired) begin
          busErr_d = 1'b1;
          resp_d   = req_q.we ? '0 : ERR_DATA;
          state_d  = RESP;
        end
      end
      RESP: begin
        dataDone = 1'b1;
`ifdef DATA_MEM_WRITE_BUFFER_EN
        state_d  = req_q.we ? DRAIN : IDLE;
`else
        state_d  = IDLE;
`endif
      end
`ifdef DATA_MEM_WRITE_BUFFER_EN
      DRAIN: begin
        memReq = 1'b1;
        if (memAck_i) begin
          state_d = IDLE;
        end else if (expired) begin
          busErr_d = 1'b1;
          state_d  = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_q    <= '0;
      resp_q   <= '0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      resp_q   <= resp_d;
      busErr_q <= busErr_d;
    end
  end

  assign dataIn_o   = resp_q;
  assign dataDone_o = dataDone;
  assign memReq_o   = memReq;
  assign memWe_o    = memReq && req_q.we;
  assign memAddr_o  = req_q.addr;
  assign memWData_o = req_q.wdata;
  assign busErr_o   = busErr_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver pushes expected responses, monitor checks them on DataDone.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] dataAddr;
  logic [15:0] dataOut;
  logic        readData;
  logic        writeData;
  logic [15:0] dataIn;
  logic        dataDone;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memAck;
  logic        busErr;
  logic        busy;

  data_mem_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dataAddr_i (dataAddr),
    .dataOut_i  (dataOut),
    .readData_i (readData),
    .writeData_i(writeData),
    .dataIn_o   (dataIn),
    .dataDone_o (dataDone),
    .memReq_o   (memReq),
    .memWe_o    (memWe),
    .memAddr_o  (memAddr),
    .memWData_o (memWData),
    .memRData_i (memRData),
    .memAck_i   (memAck),
    .busErr_o   (busErr),
    .busy_o     (busy)
  );

  typedef struct {
    string       name;
    logic [15:0] data;
    int          cyc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a DataDone while a request is held is a response to be scored.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (readData || writeData) && dataDone) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, ".data"}, 32'(dataIn), 32'(e.data));
        checkOutput({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
        checkOutput({e.name, ".busErr"}, 32'(busErr), 32'(e.err));
      end
    end
  end

  // Runs one request: ackCyc = 0 means the bus never acknowledges.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input int ackCyc, input logic [15:0] rdata,
                               input logic [15:0] expData, input int expLat, input logic expErr);
    exp_t e;
    int   firstReq;
    int   reqCnt;
    bit   done;
    logic seenWe;
    logic [15:0] seenAddr, seenWData;
    firstReq  = -1;
    reqCnt    = 0;
    done      = 1'b0;
    seenWe    = 1'b0;
    seenAddr  = '0;
    seenWData = '0;
    readData  = rd;
    writeData = wr;
    dataAddr  = addr;
    dataOut   = wdata;
    e.name = name;
    e.data = expData;
    e.cyc  = cyc + expLat;
    e.err  = expErr;
    sb.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      memAck   = (ackCyc != 0) && (c == ackCyc);
      memRData = memAck ? rdata : 16'h0BAD;
      @(negedge clk);
      if (memReq) begin
        reqCnt++;
        if (firstReq < 0) firstReq = c;
        if (c == 1) begin
          seenWe    = memWe;
          seenAddr  = memAddr;
          seenWData = memWData;
        end
      end
      if (dataDone) done = 1'b1;
      @(posedge clk);
      #1;
    end
    memAck    = 1'b0;
    readData  = 1'b0;
    writeData = 1'b0;
    checkOutput({name, ".completed"}, 32'(done), 32'd1);
    checkOutput({name, ".firstReq"}, 32'(firstReq), 32'd1);
    checkOutput({name, ".reqCycles"}, 32'(reqCnt), 32'(expLat - 1));
    checkOutput({name, ".memAddr"}, 32'(seenAddr), 32'(addr));
    checkOutput({name, ".memWe"}, 32'(seenWe), 32'(wr));
    if (wr) checkOutput({name, ".memWData"}, 32'(seenWData), 32'(wdata));
  endtask

  task automatic idleCycles(input string name, input int n, input int strayAt, input logic [15:0] holdData);
    for (int c = 0; c < n; c++) begin
      memAck   = (c == strayAt);
      memRData = 16'hFFFF;
      @(negedge clk);
      checkOutput($sformatf("%s.c%0d", name, c), {12'h0, dataDone, memReq, busy, busErr, dataIn},
                  {12'h0, 1'b1, 1'b0, 1'b0, 1'b0, holdData});
      @(posedge clk);
      #1;
    end
    memAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    dataAddr  = '0;
    dataOut   = '0;
    readData  = 1'b0;
    writeData = 1'b0;
    memRData  = '0;
    memAck    = 1'b0;
    #12;
    checkOutput("reset.dataDone", 32'(dataDone), 32'd1);
    checkOutput("reset.memReq", 32'(memReq), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.outs", {memWe, busErr, dataIn, memAddr[13:0]}, 32'd0);
    checkOutput("reset.wdata", 32'(memWData), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    idleCycles("idle", 3, -1, 16'h0000);
    applyStimulus("read1", 1'b1, 1'b0, 16'h0010, 16'h0000, 3, 16'h1234, 16'h1234, 4, 1'b0);
    idleCycles("stray", 10, 5, 16'h1234);

`ifndef DATA_MEM_WRITE_BUFFER_EN
    applyStimulus("write1", 1'b0, 1'b1, 16'h0020, 16'hBEEF, 1, 16'h5555, 16'h0000, 2, 1'b0);
    @(negedge clk);
    checkOutput("writeHold", 32'(dataIn), 32'h0000);
    @(posedge clk);
    #1;
    applyStimulus("bothHigh", 1'b1, 1'b1, 16'h0030, 16'h1111, 2, 16'h2222, 16'h0000, 3, 1'b0);
`else
    // Posted store (ack in cycle 4 of drain), then a load presented in cycle 2.
    begin
      exp_t e;
      int   t0;
      t0 = cyc;
      writeData = 1'b1;
      dataAddr  = 16'h0050;
      dataOut   = 16'hCAFE;
      e.name = "store"; e.data = 16'h0000; e.cyc = t0 + 1; e.err = 1'b0;
      sb.push_back(e);
      e.name = "load";  e.data = 16'h4321; e.cyc = t0 + 8; e.err = 1'b0;
      sb.push_back(e);
      for (int c = 0; c < 10; c++) begin
        if (c == 2) begin
          writeData = 1'b0;
          readData  = 1'b1;
          dataAddr  = 16'h0060;
        end
        if (c == 9) readData = 1'b0;
        memAck   = (c == 4) || (c == 7);
        memRData = (c == 7) ? 16'h4321 : 16'h0BAD;
        @(negedge clk);
        if (c == 2) checkOutput("wb.loadWaits2", 32'(dataDone), 32'd0);
        if (c == 3) checkOutput("wb.drainWrite", {memReq, memWe, memWData}, {16'h0, 1'b1, 1'b1, 16'hCAFE});
        if (c == 5) checkOutput("wb.loadWaits5", {dataDone, memReq}, 32'd0);
        if (c == 6) checkOutput("wb.loadReq", {memReq, memWe, memAddr}, {16'h0, 1'b1, 1'b0, 16'h0060});
        @(posedge clk);
        #1;
      end
      memAck = 1'b0;
    end
`endif

    applyStimulus("timeout", 1'b1, 1'b0, 16'h0070, 16'h0000, 0, 16'h0000, 16'hDEAD, 16, 1'b1);
    applyStimulus("read2", 1'b1, 1'b0, 16'h0080, 16'h0000, 2, 16'h5A5A, 16'h5A5A, 3, 1'b1);
    applyStimulus("ackLast", 1'b1, 1'b0, 16'h0090, 16'h0000, 15, 16'h7777, 16'h7777, 16, 1'b1);

    // Reset while the bus request is up must drop MemReq without waiting for a clock.
    readData = 1'b1;
    dataAddr = 16'h0040;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rstMid.reqBefore", 32'(memReq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstMid.reqDropped", 32'(memReq), 32'd0);
    checkOutput("rstMid.busy", 32'(busy), 32'd0);
    readData = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstMid.after", {dataDone, busy, busErr, memReq}, 32'b1000);
    @(posedge clk);
    #1;

    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
